// File: rtl/pcie_vc_arbiter_pkg.sv
// Shared transfer-layer definitions: one-hot arbiter/demux state encodings
// and the virtual-channel count.
package pcie_vc_arbiter_pkg;

  localparam int NUM_VC  = 4;
  localparam int GRANT_W = $clog2(NUM_VC);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_e;

endpackage

// File: rtl/rr_next_sel.sv
// Round-robin search: the first non-empty channel after the current grant,
// scanning grant+1 .. grant+3 modulo the channel count.
module rr_next_sel
  import pcie_vc_arbiter_pkg::*;
(
  input  logic [GRANT_W-1:0] grant,
  input  logic [NUM_VC-1:0]  fifo_empty,
  output logic [GRANT_W-1:0] next,
  output logic               found
);

  logic [GRANT_W-1:0] idx;

  // NOTE: every output gets a default before the search so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    next  = grant;
    found = 1'b0;
    idx   = grant;
    // Scan farthest-first so the nearest candidate is the last one written.
    for (int k = NUM_VC - 1; k >= 1; k--) begin
      idx = grant + GRANT_W'(k);
      if (!fifo_empty[idx]) begin
        next  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_vc_arbiter.sv
// Weighted round-robin scheduler for the four VC FIFOs: issues one-hot pop
// strobes and feeds the demux a delayed valid vector and the one-hot state.
module pcie_vc_arbiter
  import pcie_vc_arbiter_pkg::*;
#(
  parameter int BURST   = 4,
  parameter int BURST_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [NUM_VC-1:0]  fifo_empty,
  input  logic               out_almost_full,
  output logic [NUM_VC-1:0]  pop,
  output logic [NUM_VC-1:0]  valid,
  output logic [3:0]         state,
  output logic [GRANT_W-1:0] grant,
  output logic               idle
);

  state_e               state_q;
  logic [GRANT_W-1:0]   grant_q;
  logic [BURST_W-1:0]   burst_q;
  logic [NUM_VC-1:0]    valid_q;
  logic [GRANT_W-1:0]   next_grant;
  logic                 next_found;
  logic                 pop_any;
  logic                 all_empty;
  logic                 burst_last;

  rr_next_sel u_next_sel (
    .grant      (grant_q),
    .fifo_empty (fifo_empty),
    .next       (next_grant),
    .found      (next_found)
  );

  assign all_empty  = &fifo_empty;
  assign burst_last = (burst_q == BURST_W'(BURST - 1));

  // init suppresses the pop in the very cycle ACTIVE is abandoned.
  always_comb begin
    pop = '0;
    if (state_q == ST_ACTIVE && !init && !fifo_empty[grant_q] && !out_almost_full)
      pop[grant_q] = 1'b1;
  end

  assign pop_any = |pop;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
      grant_q <= '0;
      burst_q <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= pop;
      case (state_q)
        ST_RESET: state_q <= ST_INIT;
        ST_INIT: begin
          if (!init) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (init) begin
            state_q <= ST_INIT;
            grant_q <= '0;
            burst_q <= '0;
          end else if (!all_empty) begin
            state_q <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (init) begin
            state_q <= ST_INIT;
            grant_q <= '0;
            burst_q <= '0;
          end else begin
            if (all_empty) state_q <= ST_IDLE;
            if (pop_any) begin
              if (burst_last) begin
                burst_q <= '0;
                if (next_found) grant_q <= next_grant;
              end else begin
                burst_q <= burst_q + 1'b1;
              end
            end else if (fifo_empty[grant_q]) begin
              // Granted FIFO ran dry: one bubble, then move on.
              burst_q <= '0;
              if (next_found) grant_q <= next_grant;
            end
          end
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end

  assign state = state_q;
  assign grant = grant_q;
  assign valid = valid_q;
  assign idle  = (state_q == ST_IDLE) && all_empty;

endmodule

// File: tb/tb_pcie_vc_arbiter.sv
// Self-checking bench for pcie_vc_arbiter: directed vector table, hand-written
// corner sequences, then random traffic against a behavioural model.
module tb_pcie_vc_arbiter;

  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       reset, init, out_almost_full;
  logic [3:0] fifo_empty;
  logic [3:0] pop, valid, state;
  logic [1:0] grant;
  logic       idle;

  int checks   = 0;
  int failures = 0;

  pcie_vc_arbiter #(.BURST(BURST), .BURST_W(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .init            (init),
    .fifo_empty      (fifo_empty),
    .out_almost_full (out_almost_full),
    .pop             (pop),
    .valid           (valid),
    .state           (state),
    .grant           (grant),
    .idle            (idle)
  );

  always #5 clk = ~clk;

  // Model: state as an index 0..3 (RESET, INIT, IDLE, ACTIVE), plain integers.
  int         m_st, m_g, m_c;
  logic [3:0] m_valid;

  typedef struct {
    logic       r, i;
    logic [3:0] fe;
    logic       af;
    logic [3:0] st, pop, valid;
    logic [1:0] grant;
    logic       idle;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] model_pop();
    if (m_st == 3 && !init && !fifo_empty[m_g] && !out_almost_full)
      return 4'(1 << m_g);
    return 4'b0000;
  endfunction

  function automatic int model_advance(int g, logic [3:0] fe);
    for (int k = 1; k < 4; k++)
      if (!fe[(g + k) % 4]) return (g + k) % 4;
    return g;
  endfunction

  task automatic model_update();
    logic [3:0] p;
    p = model_pop();
    if (reset) begin
      m_st = 0; m_g = 0; m_c = 0; m_valid = 4'b0000;
    end else begin
      m_valid = p;
      if (m_st == 0) m_st = 1;
      else if (m_st == 1) begin
        if (!init) m_st = 2;
      end else if (init) begin
        m_st = 1; m_g = 0; m_c = 0;
      end else if (m_st == 2) begin
        if (fifo_empty != 4'hF) m_st = 3;
      end else begin
        if (fifo_empty == 4'hF) m_st = 2;
        if (p != 0) begin
          if (m_c == BURST - 1) begin
            m_c = 0; m_g = model_advance(m_g, fifo_empty);
          end else m_c++;
        end else if (fifo_empty[m_g]) begin
          m_c = 0; m_g = model_advance(m_g, fifo_empty);
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic i, input logic [3:0] fe, input logic af);
    reset = r; init = i; fifo_empty = fe; out_almost_full = af;
    #2;
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".state"}, {4'b0, state}, {4'b0, 4'(1 << m_st)});
    check({tag, ".grant"}, {6'b0, grant}, 8'(m_g));
    check({tag, ".pop"},   {4'b0, pop},   {4'b0, model_pop()});
    check({tag, ".valid"}, {4'b0, valid}, {4'b0, m_valid});
    check({tag, ".idle"},  {7'b0, idle},  {7'b0, (m_st == 2 && fifo_empty == 4'hF)});
  endtask

  initial begin
    // Reset, bring-up, then only channel 2 carrying traffic, then drain.
    //           r  i  fe       af  st       pop      valid    g  idle
    vecs[0]  = '{1, 0, 4'hF,    0, 4'b0001, 4'b0000, 4'b0000, 0, 0};
    vecs[1]  = '{0, 0, 4'hF,    0, 4'b0001, 4'b0000, 4'b0000, 0, 0};
    vecs[2]  = '{0, 0, 4'hF,    0, 4'b0010, 4'b0000, 4'b0000, 0, 0};
    vecs[3]  = '{0, 0, 4'hF,    0, 4'b0100, 4'b0000, 4'b0000, 0, 1};
    vecs[4]  = '{0, 0, 4'b1011, 0, 4'b0100, 4'b0000, 4'b0000, 0, 0};
    vecs[5]  = '{0, 0, 4'b1011, 0, 4'b1000, 4'b0000, 4'b0000, 0, 0};
    vecs[6]  = '{0, 0, 4'b1011, 0, 4'b1000, 4'b0100, 4'b0000, 2, 0};
    vecs[7]  = '{0, 0, 4'b1011, 0, 4'b1000, 4'b0100, 4'b0100, 2, 0};
    vecs[8]  = '{0, 0, 4'b1011, 0, 4'b1000, 4'b0100, 4'b0100, 2, 0};
    vecs[9]  = '{0, 0, 4'b1011, 0, 4'b1000, 4'b0100, 4'b0100, 2, 0};
    vecs[10] = '{0, 0, 4'hF,    0, 4'b1000, 4'b0000, 4'b0100, 2, 0};
    vecs[11] = '{0, 0, 4'hF,    0, 4'b0100, 4'b0000, 4'b0000, 2, 1};

    drive(1, 0, 4'hF, 0);
    tick();
    for (int n = 0; n < 12; n++) begin
      drive(vecs[n].r, vecs[n].i, vecs[n].fe, vecs[n].af);
      check($sformatf("vec%0d.state", n), {4'b0, state}, {4'b0, vecs[n].st});
      check($sformatf("vec%0d.pop", n),   {4'b0, pop},   {4'b0, vecs[n].pop});
      check($sformatf("vec%0d.valid", n), {4'b0, valid}, {4'b0, vecs[n].valid});
      check($sformatf("vec%0d.grant", n), {6'b0, grant}, {6'b0, vecs[n].grant});
      check($sformatf("vec%0d.idle", n),  {7'b0, idle},  {7'b0, vecs[n].idle});
      tick();
    end

    // Pass through INIT to bring grant back to 0, then all four channels busy.
    drive(0, 1, 4'hF, 0); tick();
    drive(0, 0, 4'hF, 0);
    check("reinit.state", {4'b0, state}, 8'h02);
    check("reinit.grant", {6'b0, grant}, 8'h00);
    tick();
    drive(0, 0, 4'h0, 0);
    check("reinit.idle_state", {4'b0, state}, 8'h04);
    tick();
    for (int n = 0; n < 18; n++) begin
      drive(0, 0, 4'h0, 0);
      check($sformatf("burst%0d.pop", n), {4'b0, pop}, 8'(1 << ((n / 4) % 4)));
      check($sformatf("burst%0d.valid", n), {4'b0, valid},
            (n == 0) ? 8'h00 : 8'(1 << (((n - 1) / 4) % 4)));
      tick();
    end

    // Back-pressure with two pops already taken on channel 0.
    for (int n = 0; n < 3; n++) begin
      drive(0, 0, 4'h0, 1);
      check($sformatf("bp%0d.pop", n), {4'b0, pop}, 8'h00);
      check($sformatf("bp%0d.grant", n), {6'b0, grant}, 8'h00);
      tick();
    end
    drive(0, 0, 4'h0, 0); check("bp_rel0.pop", {4'b0, pop}, 8'h01); tick();
    drive(0, 0, 4'h0, 0); check("bp_rel1.pop", {4'b0, pop}, 8'h01); tick();
    drive(0, 0, 4'h0, 0); check("bp_rot.pop",  {4'b0, pop}, 8'h02); tick();

    // init while ACTIVE mid-burst on channel 1.
    drive(0, 1, 4'h0, 0);
    check("init.pop", {4'b0, pop}, 8'h00);
    check("init.state", {4'b0, state}, 8'h08);
    tick();
    drive(0, 0, 4'h0, 0);
    check("init_after.state", {4'b0, state}, 8'h02);
    check("init_after.grant", {6'b0, grant}, 8'h00);
    check("init_after.valid", {4'b0, valid}, 8'h00);
    tick();
    check("init_idle.state", {4'b0, state}, 8'h04);
    check("init_idle.pop", {4'b0, pop}, 8'h00);
    tick();
    check("init_resume.state", {4'b0, state}, 8'h08);
    check("init_resume.pop", {4'b0, pop}, 8'h01);
    tick();

    // Reset with a pop in flight.
    drive(0, 0, 4'h0, 0); check("rst_pre.pop", {4'b0, pop}, 8'h01); tick();
    drive(1, 0, 4'h0, 0); check("rst_hit.valid", {4'b0, valid}, 8'h01); tick();
    drive(1, 0, 4'h0, 0);
    check("rst_after.state", {4'b0, state}, 8'h01);
    check("rst_after.valid", {4'b0, valid}, 8'h00);
    check("rst_after.pop",   {4'b0, pop},   8'h00);
    tick();
    drive(0, 0, 4'h0, 0);
    check("rst_rel.pop",   {4'b0, pop},   8'h00);
    check("rst_rel.valid", {4'b0, valid}, 8'h00);
    tick();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] fe;
      fe = 4'($urandom);
      if ($urandom_range(0, 3) == 0) fe = 4'hF;
      else if ($urandom_range(0, 3) == 0) fe = 4'h0;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, fe,
            $urandom_range(0, 3) == 0);
      check_model($sformatf("rnd%0d", n));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
